// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and the MEM-stage data requester.
// Sequences each access IDLE -> WAIT -> DONE and returns a registered one-cycle ready pulse.
module mem_port_arbiter #(
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_mem
);

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             owner_data;
  logic             last_grant_data;
  logic             d_req;
  logic             grant;
  logic             grant_data;
  logic             capture;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // On a tie the requester that did not own the previous access wins.
  always_comb begin
    state_nxt  = state;
    grant      = 1'b0;
    grant_data = 1'b0;
    capture    = 1'b0;
    d_req      = d_read | d_write;
    case (state)
      IDLE: begin
        if (if_req | d_req) begin
          grant      = 1'b1;
          grant_data = d_req & (~if_req | ~last_grant_data);
          state_nxt  = WAIT;
        end
      end
      WAIT: begin
        if (cnt == CNT_W'(1)) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if_rdata        <= '0;
      d_rdata         <= '0;
      if_ready        <= 1'b0;
      d_ready         <= 1'b0;
      mem_en          <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      cnt             <= '0;
      owner_data      <= 1'b0;
      last_grant_data <= 1'b1;
    end else begin
      mem_en   <= grant;
      if_ready <= capture & ~owner_data;
      d_ready  <= capture & owner_data;
      if (grant) begin
        mem_addr   <= grant_data ? d_addr : if_addr;
        mem_we     <= grant_data & d_write;
        mem_wdata  <= grant_data ? d_wdata : '0;
        owner_data <= grant_data;
        cnt        <= CNT_W'(MEM_LATENCY);
      end else if (state == WAIT) begin
        cnt <= cnt - CNT_W'(1);
      end
      // mem_we is still held from the grant, so it tells a write apart from a read here.
      if (capture) begin
        last_grant_data <= owner_data;
        if (!mem_we) begin
          if (owner_data) d_rdata  <= mem_rdata;
          else            if_rdata <= mem_rdata;
        end
      end
    end
  end

  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = (d_read | d_write) & ~d_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run against a cycle-timeline model.
module tb_mem_port_arbiter;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_read, d_write;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ready, d_ready, mem_en, mem_we, stall_if, stall_mem;

  logic        if_req1, d_read1, d_write1;
  logic [31:0] if_addr1, d_addr1, d_wdata1, mem_rdata1;
  logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1;
  logic        if_ready1, d_ready1, mem_en1, mem_we1, stall_if1, stall_mem1;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          data_cyc = -10;
  logic [31:0] data_val = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
  );

  mem_port_arbiter #(.MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_ready(if_ready1),
    .d_read(d_read1), .d_write(d_write1), .d_addr(d_addr1), .d_wdata(d_wdata1),
    .d_rdata(d_rdata1), .d_ready(d_ready1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .stall_if(stall_if1), .stall_mem(stall_mem1)
  );

  function automatic logic [31:0] mem_value(input logic [31:0] a);
    logic [31:0] p;
    p = a * 32'h9E37_79B1;
    return p ^ 32'h8C01_0004;
  endfunction

  // Start of a cycle: memory drives data only in the cycle it is valid, junk otherwise.
  task automatic step_a;
    @(posedge clk);
    #1;
    cyc++;
    if (cyc == data_cyc) mem_rdata = data_val;
    else                 mem_rdata = $urandom;
  endtask

  task automatic step_b;
    @(negedge clk);
    if (mem_en === 1'b1) begin
      data_cyc = cyc + LAT - 1;
      data_val = mem_value(mem_addr);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; if_req = 1'b1; if_addr = 32'h0; d_read = 1'b0; d_write = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step_a; step_b;
      vectors++;
      if ({if_ready, d_ready, mem_en, mem_we} !== 4'b0 || if_rdata !== 32'h0 ||
          d_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_outputs: got rdy=%b%b en=%b we=%b addr=%h wd=%h ifr=%h dr=%h, expected all 0",
                 if_ready, d_ready, mem_en, mem_we, mem_addr, mem_wdata, if_rdata, d_rdata);
      end
      vectors++;
      if (stall_if !== 1'b1) begin
        miscompares++; $display("FAIL reset_stall_if: got %b expected 1", stall_if);
      end
    end
    step_a; reset = 1'b1; step_b;
    vectors++;
    if (mem_en !== 1'b0) begin miscompares++; $display("FAIL rel_mem_en k0: got %b expected 0", mem_en); end
    for (int k = 1; k <= 4; k++) begin
      step_a; if (k == 4) if_req = 1'b0; step_b;
      vectors++;
      if (mem_en !== (k == 1)) begin
        miscompares++; $display("FAIL rel_mem_en k%0d: got %b expected %b", k, mem_en, (k == 1));
      end
      vectors++;
      if (if_ready !== (k == 3)) begin
        miscompares++; $display("FAIL rel_if_ready k%0d: got %b expected %b", k, if_ready, (k == 3));
      end
      vectors++;
      if (stall_if !== (k < 3)) begin
        miscompares++; $display("FAIL rel_stall_if k%0d: got %b expected %b", k, stall_if, (k < 3));
      end
      if (k == 3) begin
        vectors++;
        if (if_rdata !== 32'h8C01_0004) begin
          miscompares++; $display("FAIL rel_if_rdata: got %h expected 8c010004", if_rdata);
        end
      end
    end
  endtask

  task automatic test_tie;
    step_a; reset = 1'b0; if_req = 1'b1; if_addr = 32'h4; d_read = 1'b1; d_addr = 32'h1000; step_b;
    step_a; reset = 1'b1; step_b;
    vectors++;
    if (mem_en !== 1'b0) begin miscompares++; $display("FAIL tie_mem_en k0: got %b expected 0", mem_en); end
    for (int k = 1; k <= 8; k++) begin
      step_a; if (k == 4) if_req = 1'b0; if (k == 8) d_read = 1'b0; step_b;
      vectors++;
      if (mem_en !== (k == 1 || k == 5)) begin
        miscompares++; $display("FAIL tie_mem_en k%0d: got %b expected %b", k, mem_en, (k == 1 || k == 5));
      end
      vectors++;
      if (if_ready !== (k == 3) || d_ready !== (k == 7)) begin
        miscompares++; $display("FAIL tie_ready k%0d: got if=%b d=%b expected if=%b d=%b",
                                k, if_ready, d_ready, (k == 3), (k == 7));
      end
      vectors++;
      if (stall_mem !== (k < 7)) begin
        miscompares++; $display("FAIL tie_stall_mem k%0d: got %b expected %b", k, stall_mem, (k < 7));
      end
      if (k == 1 || k == 5) begin
        vectors++;
        if (mem_addr !== ((k == 1) ? 32'h4 : 32'h1000) || mem_we !== 1'b0) begin
          miscompares++; $display("FAIL tie_grant k%0d: got addr=%h we=%b expected addr=%h we=0",
                                  k, mem_addr, mem_we, (k == 1) ? 32'h4 : 32'h1000);
        end
      end
      if (k == 3) begin
        vectors++;
        if (if_rdata !== mem_value(32'h4)) begin
          miscompares++; $display("FAIL tie_if_rdata: got %h expected %h", if_rdata, mem_value(32'h4));
        end
      end
      if (k == 7) begin
        vectors++;
        if (d_rdata !== mem_value(32'h1000)) begin
          miscompares++; $display("FAIL tie_d_rdata: got %h expected %h", d_rdata, mem_value(32'h1000));
        end
      end
    end
  endtask

  task automatic test_write;
    step_a; d_write = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF; step_b;
    for (int k = 1; k <= 4; k++) begin
      step_a; if (k == 4) d_write = 1'b0; step_b;
      vectors++;
      if (mem_en !== (k == 1)) begin
        miscompares++; $display("FAIL wr_mem_en k%0d: got %b expected %b", k, mem_en, (k == 1));
      end
      vectors++;
      if (mem_we !== 1'b1 || mem_addr !== 32'h10 || mem_wdata !== 32'hDEAD_BEEF) begin
        miscompares++; $display("FAIL wr_bus k%0d: got we=%b addr=%h wd=%h expected we=1 addr=10 wd=deadbeef",
                                k, mem_we, mem_addr, mem_wdata);
      end
      vectors++;
      if (d_ready !== (k == 3)) begin
        miscompares++; $display("FAIL wr_d_ready k%0d: got %b expected %b", k, d_ready, (k == 3));
      end
      vectors++;
      if (d_rdata !== mem_value(32'h1000)) begin
        miscompares++; $display("FAIL wr_d_rdata k%0d: got %h expected %h", k, d_rdata, mem_value(32'h1000));
      end
      vectors++;
      if (stall_mem !== (k < 3)) begin
        miscompares++; $display("FAIL wr_stall_mem k%0d: got %b expected %b", k, stall_mem, (k < 3));
      end
    end
  endtask

  task automatic test_fairness;
    int j;
    logic [31:0] ea;
    for (int k = 0; k <= 24; k++) begin
      step_a;
      j = k / 4;
      if (k < 24) begin
        if_req = 1'b1; if_addr = 32'h200 + 32'(4 * ((j + 1) / 2));
        d_read = 1'b1; d_addr = 32'h3000 + 32'(4 * (j / 2));
      end else begin
        if_req = 1'b0; d_read = 1'b0;
      end
      step_b;
      ea = ((j % 2) == 0) ? 32'h200 + 32'(4 * (j / 2)) : 32'h3000 + 32'(4 * (j / 2));
      vectors++;
      if (mem_en !== ((k % 4) == 1)) begin
        miscompares++; $display("FAIL fair_mem_en k%0d: got %b expected %b", k, mem_en, ((k % 4) == 1));
      end
      if ((k % 4) == 1) begin
        vectors++;
        if (mem_addr !== ea) begin
          miscompares++; $display("FAIL fair_grant_addr k%0d: got %h expected %h", k, mem_addr, ea);
        end
      end
      vectors++;
      if (if_ready !== ((k % 4) == 3 && (j % 2) == 0) || d_ready !== ((k % 4) == 3 && (j % 2) == 1)) begin
        miscompares++; $display("FAIL fair_ready k%0d: got if=%b d=%b expected if=%b d=%b", k, if_ready, d_ready,
                                ((k % 4) == 3 && (j % 2) == 0), ((k % 4) == 3 && (j % 2) == 1));
      end
      if ((k % 4) == 3) begin
        vectors++;
        if ((((j % 2) == 0) ? if_rdata : d_rdata) !== mem_value(ea)) begin
          miscompares++; $display("FAIL fair_rdata k%0d: got %h expected %h", k,
                                  ((j % 2) == 0) ? if_rdata : d_rdata, mem_value(ea));
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    for (int k = 0; k <= 7; k++) begin
      step_a;
      if (k == 0) begin if_req = 1'b1; if_addr = 32'h44; end
      if (k == 2) reset = 1'b0;
      if (k == 3) reset = 1'b1;
      if (k == 7) if_req = 1'b0;
      step_b;
      vectors++;
      if (mem_en !== (k == 1 || k == 4)) begin
        miscompares++; $display("FAIL mid_mem_en k%0d: got %b expected %b", k, mem_en, (k == 1 || k == 4));
      end
      vectors++;
      if (if_ready !== (k == 6) || d_ready !== 1'b0) begin
        miscompares++; $display("FAIL mid_ready k%0d: got if=%b d=%b expected if=%b d=0", k, if_ready, d_ready, (k == 6));
      end
      if (k == 3) begin
        vectors++;
        if (if_rdata !== 32'h0 || d_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_we !== 1'b0 || mem_wdata !== 32'h0) begin
          miscompares++; $display("FAIL mid_cleared: got ifr=%h dr=%h addr=%h we=%b wd=%h expected all 0",
                                  if_rdata, d_rdata, mem_addr, mem_we, mem_wdata);
        end
      end
      if (k == 4) begin
        vectors++;
        if (mem_addr !== 32'h44) begin
          miscompares++; $display("FAIL mid_reissue_addr: got %h expected 00000044", mem_addr);
        end
      end
      if (k == 6) begin
        vectors++;
        if (if_rdata !== mem_value(32'h44)) begin
          miscompares++; $display("FAIL mid_if_rdata: got %h expected %h", if_rdata, mem_value(32'h44));
        end
      end
    end
  endtask

  task automatic test_drop_l1;
    for (int k = 0; k <= 6; k++) begin
      step_a;
      mem_rdata1 = (k == 1) ? 32'hCAFE_F00D : (k == 4) ? 32'h1122_3344 : $urandom;
      if (k == 0) begin d_read1 = 1'b1; d_addr1 = 32'h80; end
      if (k == 1) begin d_read1 = 1'b0; if_req1 = 1'b1; if_addr1 = 32'h90; end
      if (k == 6) if_req1 = 1'b0;
      step_b;
      vectors++;
      if (mem_en1 !== (k == 1 || k == 4)) begin
        miscompares++; $display("FAIL l1_mem_en k%0d: got %b expected %b", k, mem_en1, (k == 1 || k == 4));
      end
      vectors++;
      if (d_ready1 !== (k == 2) || if_ready1 !== (k == 5)) begin
        miscompares++; $display("FAIL l1_ready k%0d: got d=%b if=%b expected d=%b if=%b",
                                k, d_ready1, if_ready1, (k == 2), (k == 5));
      end
      vectors++;
      if (stall_mem1 !== (k == 0)) begin
        miscompares++; $display("FAIL l1_stall_mem k%0d: got %b expected %b", k, stall_mem1, (k == 0));
      end
      if (k == 1) begin
        vectors++;
        if (mem_addr1 !== 32'h80) begin miscompares++; $display("FAIL l1_addr: got %h expected 00000080", mem_addr1); end
      end
      if (k >= 2) begin
        vectors++;
        if (d_rdata1 !== 32'hCAFE_F00D) begin
          miscompares++; $display("FAIL l1_d_rdata k%0d: got %h expected cafef00d", k, d_rdata1);
        end
      end
      if (k == 5) begin
        vectors++;
        if (if_rdata1 !== 32'h1122_3344) begin
          miscompares++; $display("FAIL l1_if_rdata: got %h expected 11223344", if_rdata1);
        end
      end
    end
  endtask

  // Model works on the cycle timeline: a grant in cycle T means strobe at T+1, ready at
  // T+LAT+1, and the next decision no earlier than T+LAT+2.
  task automatic test_random;
    int m_free, pend_en, pend_rdy, op;
    bit m_last_d, pend_d, pend_we, if_act, d_act, if_done, d_done, rdy_now, grant, gd, exp_we;
    logic [31:0] pend_addr, exp_ifr, exp_dr, exp_ma, exp_wd;
    step_a; reset = 1'b0; if_req = 1'b0; d_read = 1'b0; d_write = 1'b0; step_b;
    m_free = 0; pend_en = -1; pend_rdy = -1; m_last_d = 1'b1; pend_d = 1'b0; pend_we = 1'b0;
    pend_addr = '0; exp_ifr = '0; exp_dr = '0; exp_ma = '0; exp_wd = '0; exp_we = 1'b0;
    if_act = 1'b0; d_act = 1'b0; if_done = 1'b0; d_done = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      step_a;
      if (if_done) if_act = 1'b0;
      if (!if_act && ($urandom % 3) != 0) begin if_act = 1'b1; if_addr = $urandom; end
      if (d_done) d_act = 1'b0;
      if (!d_act && ($urandom % 3) != 0) begin
        d_act = 1'b1; op = int'($urandom % 3);
        d_read = (op != 1); d_write = (op != 0); d_addr = $urandom; d_wdata = $urandom;
      end
      if_req = if_act;
      if (!d_act) begin d_read = 1'b0; d_write = 1'b0; end
      reset = (($urandom % 40) != 0);
      grant = 1'b0; gd = 1'b0;
      if (reset && i >= m_free && (if_req || d_read || d_write)) begin
        grant = 1'b1;
        gd = (if_req && (d_read || d_write)) ? !m_last_d : !if_req;
      end
      rdy_now = (i == pend_rdy);
      if (rdy_now) begin
        m_last_d = pend_d;
        if (!pend_we) begin
          if (pend_d) exp_dr = mem_value(pend_addr);
          else        exp_ifr = mem_value(pend_addr);
        end
      end
      step_b;
      vectors++;
      if (mem_en !== (i == pend_en)) begin
        miscompares++; $display("FAIL rnd_mem_en c%0d: got %b expected %b", i, mem_en, (i == pend_en));
      end
      vectors++;
      if (if_ready !== (rdy_now && !pend_d) || d_ready !== (rdy_now && pend_d)) begin
        miscompares++; $display("FAIL rnd_ready c%0d: got if=%b d=%b expected if=%b d=%b",
                                i, if_ready, d_ready, (rdy_now && !pend_d), (rdy_now && pend_d));
      end
      vectors++;
      if (if_rdata !== exp_ifr || d_rdata !== exp_dr) begin
        miscompares++; $display("FAIL rnd_rdata c%0d: got if=%h d=%h expected if=%h d=%h",
                                i, if_rdata, d_rdata, exp_ifr, exp_dr);
      end
      vectors++;
      if (mem_addr !== exp_ma || mem_we !== exp_we || (exp_we && mem_wdata !== exp_wd)) begin
        miscompares++; $display("FAIL rnd_bus c%0d: got addr=%h we=%b wd=%h expected addr=%h we=%b wd=%h",
                                i, mem_addr, mem_we, mem_wdata, exp_ma, exp_we, exp_wd);
      end
      vectors++;
      if (stall_if !== (if_req && !(rdy_now && !pend_d)) ||
          stall_mem !== ((d_read || d_write) && !(rdy_now && pend_d))) begin
        miscompares++; $display("FAIL rnd_stall c%0d: got if=%b mem=%b", i, stall_if, stall_mem);
      end
      if_done = rdy_now && !pend_d;
      d_done  = rdy_now && pend_d;
      if (!reset) begin
        pend_en = -1; pend_rdy = -1; m_free = i + 1; m_last_d = 1'b1; pend_we = 1'b0;
        exp_ifr = '0; exp_dr = '0; exp_ma = '0; exp_we = 1'b0; exp_wd = '0;
      end else if (grant) begin
        pend_en = i + 1; pend_rdy = i + LAT + 1; m_free = i + LAT + 2; pend_d = gd;
        pend_addr = gd ? d_addr : if_addr; pend_we = gd && d_write;
        exp_ma = pend_addr; exp_we = pend_we; exp_wd = d_wdata;
      end
    end
    step_a; reset = 1'b1; if_req = 1'b0; d_read = 1'b0; d_write = 1'b0; step_b;
  endtask

  initial begin
    reset = 1'b0; if_req = 1'b1; if_addr = '0; d_read = 1'b0; d_write = 1'b0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0;
    if_req1 = 1'b0; if_addr1 = '0; d_read1 = 1'b0; d_write1 = 1'b0;
    d_addr1 = '0; d_wdata1 = '0; mem_rdata1 = '0;
    test_reset;
    test_tie;
    test_write;
    test_fairness;
    test_reset_mid;
    test_drop_l1;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
